// File: rtl/bcd_convert_sched.sv
// bcd_convert_sched: round-robin scheduled binary-to-BCD engine.
// One shared double-dabble datapath, one operand bit per clock.
module bcd_convert_sched #(
  parameter int NREQ  = 3,
  parameter int WIDTH = 8,
  parameter int ID_W  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] bin_in,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  done,
  output logic [ID_W-1:0]       done_id,
  output logic [15:0]           bcd_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state, state_d;

  logic [ID_W-1:0]  last;
  logic [ID_W-1:0]  pick;
  logic [ID_W-1:0]  win;
  logic             any;
  logic [WIDTH-1:0] opnd;
  logic [CW-1:0]    cnt;
  logic [3:0]       hun;
  logic [3:0]       ten;
  logic [3:0]       one;
  logic [2:0]       h3;
  logic [3:0]       t3;
  logic [3:0]       o3;
  logic [11:0]      nxt;

  // first pending requester after the last one served
  always_comb begin
    any  = 1'b0;
    pick = '0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!any && req[(int'(last) + i) % NREQ]) begin
        any  = 1'b1;
        pick = ID_W'((int'(last) + i) % NREQ);
      end
    end
  end

  // hundreds never exceeds 2 for an 8-bit operand, so 3 bits suffice
  assign h3  = 3'((hun >= 4'd5) ? hun + 4'd3 : hun);
  assign t3  = (ten >= 4'd5) ? ten + 4'd3 : ten;
  assign o3  = (one >= 4'd5) ? one + 4'd3 : one;
  assign nxt = {h3, t3, o3, opnd[cnt]};

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (any) state_d = SHIFT;
      SHIFT:   if (cnt == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt     <= '0;
      last    <= ID_W'(NREQ - 1);
      win     <= '0;
      opnd    <= '0;
      cnt     <= '0;
      hun     <= '0;
      ten     <= '0;
      one     <= '0;
      done_id <= '0;
      bcd_out <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            gnt  <= NREQ'(1) << pick;
            last <= pick;
            win  <= pick;
            opnd <= bin_in[pick*WIDTH +: WIDTH];
            hun  <= '0;
            ten  <= '0;
            one  <= '0;
            cnt  <= CW'(WIDTH - 1);
          end
        end
        SHIFT: begin
          {hun, ten, one} <= nxt;
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            bcd_out <= {4'b0000, nxt};
            done_id <= win;
          end
        end
        DONE:    gnt <= '0;
        default: gnt <= '0;
      endcase
    end
  end

  assign done = (state == DONE);
  assign busy = (state != IDLE);

endmodule
